// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: issues sequential fetch requests, tags them with
// their PC, cancels in-flight fetches on redirect and buffers results for decode.
module pc_fetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'hbfc00000,
  parameter int                PC_STEP  = 4,
  parameter int                MAX_OUT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [ADDR_W-1:0] inst_rdata,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_inst
);

  // Handshakes: a request is accepted in any cycle where inst_req and
  // inst_addr_ok are both high; a response is one inst_data_ok pulse, in
  // request order; decode consumes the head whenever if_valid is high and
  // stall is low.

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  // Stale responses can pile up across back-to-back redirects, so the
  // cancel counter gets headroom beyond MAX_OUT and saturates.
  localparam int CAN_W = CNT_W + 4;

  localparam logic [CNT_W:0]   MAX_OUT_C = (CNT_W + 1)'(MAX_OUT);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(MAX_OUT - 1);

  logic              ce;
  logic [ADDR_W-1:0] pc;

  logic [ADDR_W-1:0] tag_mem [MAX_OUT];
  logic [PTR_W-1:0]  tag_rd;
  logic [PTR_W-1:0]  tag_wr;
  logic [CNT_W-1:0]  outstanding;

  logic [ADDR_W-1:0] res_pc   [MAX_OUT];
  logic [ADDR_W-1:0] res_inst [MAX_OUT];
  logic [PTR_W-1:0]  res_rd;
  logic [PTR_W-1:0]  res_wr;
  logic [CNT_W-1:0]  fifo_count;

  logic [CAN_W-1:0]  cancel_cnt;

  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W:0]    occupancy;
  logic              accept;
  logic              drop;
  logic              take;
  logic              push;
  logic              pop;
  logic [CAN_W:0]    cancel_sum;
  logic [CAN_W-1:0]  cancel_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    redirect    = flush | branch;
    redirect_pc = flush ? flush_pc : b_addr;
    occupancy   = {1'b0, outstanding} + {1'b0, fifo_count};

    inst_addr = pc;
    inst_req  = ~rst & ce & ~stall & ~redirect & (occupancy < MAX_OUT_C);
    accept    = inst_req & inst_addr_ok;

    // A response either retires a cancelled fetch or the oldest live one.
    drop = inst_data_ok & (cancel_cnt != '0);
    take = inst_data_ok & (cancel_cnt == '0) & (outstanding != '0);
    push = take & ~redirect;

    if_valid = ~rst & (fifo_count != '0) & ~redirect;
    if_pc    = res_pc[res_rd];
    if_inst  = res_inst[res_rd];
    pop      = if_valid & ~stall;

    cancel_sum  = {1'b0, cancel_cnt} - (CAN_W + 1)'(drop)
                + (CAN_W + 1)'(outstanding) - (CAN_W + 1)'(take);
    cancel_next = cancel_sum[CAN_W] ? '1 : cancel_sum[CAN_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ce          <= 1'b0;
      pc          <= RESET_PC;
      tag_rd      <= '0;
      tag_wr      <= '0;
      outstanding <= '0;
      res_rd      <= '0;
      res_wr      <= '0;
      fifo_count  <= '0;
      cancel_cnt  <= '0;
    end else begin
      ce <= 1'b1;

      // The PC only moves once fetching is enabled; redirects ignore stall.
      if (ce) begin
        if (redirect) begin
          pc <= redirect_pc;
        end else if (accept) begin
          pc <= pc + ADDR_W'(PC_STEP);
        end
      end

      if (redirect) begin
        tag_rd      <= '0;
        tag_wr      <= '0;
        outstanding <= '0;
        res_rd      <= '0;
        res_wr      <= '0;
        fifo_count  <= '0;
        cancel_cnt  <= cancel_next;
      end else begin
        if (accept) tag_wr <= ptr_inc(tag_wr);
        if (take)   tag_rd <= ptr_inc(tag_rd);
        outstanding <= outstanding + CNT_W'(accept) - CNT_W'(take);

        if (drop) cancel_cnt <= cancel_cnt - 1'b1;

        if (push) res_wr <= ptr_inc(res_wr);
        if (pop)  res_rd <= ptr_inc(res_rd);
        fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Storage arrays carry no reset; the pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (!rst && accept) tag_mem[tag_wr] <= pc;
    if (!rst && push) begin
      res_pc[res_wr]   <= tag_mem[tag_rd];
      res_inst[res_wr] <= inst_rdata;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus randomized traffic against a
// queue-based reference model and an in-order memory model.
module tb_pc_fetch_ctrl;

  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'hbfc00000;
  localparam int          PC_STEP  = 4;
  localparam int          MAX_OUT  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        branch = 1'b0;
  logic [31:0] b_addr = '0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  pc_fetch_ctrl #(
    .ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .PC_STEP(PC_STEP), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .branch(branch), .b_addr(b_addr), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  bit          m_ce = 1'b0;
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] q_tag[$];
  logic [31:0] q_opc[$];
  logic [31:0] q_oinst[$];
  int          m_cancel = 0;
  bit          e_req, e_valid;
  logic [31:0] e_addr, e_pc, e_inst;

  // memory model: instruction words of accepted fetches, answered in order
  logic [31:0] mem_q[$];
  bit          resp_en  = 1'b0;
  int          resp_pct = 100;

  function automatic void predict();
    bit redir;
    redir   = flush || branch;
    e_req   = !rst && m_ce && !stall && !redir && ((q_tag.size() + q_opc.size()) < MAX_OUT);
    e_addr  = m_pc;
    e_valid = !rst && (q_opc.size() > 0) && !redir;
    e_pc    = (q_opc.size() > 0) ? q_opc[0] : '0;
    e_inst  = (q_oinst.size() > 0) ? q_oinst[0] : '0;
  endfunction

  // drive the memory response for this cycle, then let outputs settle
  task automatic settle();
    inst_data_ok = 1'b0;
    inst_rdata   = $urandom;
    if (!rst && resp_en && mem_q.size() > 0 && $urandom_range(99, 0) < resp_pct) begin
      inst_data_ok = 1'b1;
      inst_rdata   = mem_q[0];
    end
    predict();
    #3;
  endtask

  task automatic advance();
    bit          acc, pop, redir, dok;
    logic [31:0] rd, t;
    acc   = e_req && inst_addr_ok;
    pop   = e_valid && !stall;
    redir = flush || branch;
    dok   = inst_data_ok;
    rd    = inst_rdata;
    @(posedge clk);
    if (rst) begin
      m_ce = 1'b0; m_pc = RESET_PC; m_cancel = 0;
      q_tag.delete(); q_opc.delete(); q_oinst.delete(); mem_q.delete();
    end else begin
      if (dok) void'(mem_q.pop_front());
      if (acc) mem_q.push_back($urandom);
      if (pop) begin void'(q_opc.pop_front()); void'(q_oinst.pop_front()); end
      if (dok) begin
        if (m_cancel > 0) m_cancel--;
        else if (q_tag.size() > 0) begin
          t = q_tag.pop_front();
          if (!redir) begin q_opc.push_back(t); q_oinst.push_back(rd); end
        end
      end
      if (redir) begin
        m_cancel += q_tag.size();
        q_tag.delete(); q_opc.delete(); q_oinst.delete();
        if (m_ce) m_pc = flush ? flush_pc : b_addr;
      end else if (acc) begin
        q_tag.push_back(m_pc);
        m_pc = m_pc + PC_STEP;
      end
      m_ce = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 0; flush = 0; branch = 0; inst_addr_ok = 0; resp_en = 0; resp_pct = 100;
    repeat (3) begin settle(); advance(); end
    rst = 1'b0;
    settle(); advance();
  endtask

  task automatic test_reset();
    rst = 1'b1; inst_addr_ok = 1'b1;
    repeat (3) begin settle(); advance(); end
    settle();
    n_cmp++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", inst_req); end
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", if_valid); end
    n_cmp++; if (inst_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_pc got %h exp %h", inst_addr, RESET_PC); end
    advance();
    rst = 1'b0; inst_addr_ok = 1'b0;
    settle();
    n_cmp++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL ce_first_cycle got %b exp 0", inst_req); end
    advance();
    settle();
    n_cmp++; if (inst_req !== 1'b1 || inst_addr !== RESET_PC) begin
      n_fail++; $display("FAIL ce_enabled got req=%b addr=%h exp req=1 addr=%h", inst_req, inst_addr, RESET_PC);
    end
    advance();
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr[3];
    exp_addr[0] = 32'hbfc00000; exp_addr[1] = 32'hbfc00004; exp_addr[2] = 32'hbfc00008;
    do_reset();
    inst_addr_ok = 1'b1; resp_en = 1'b1; resp_pct = 100;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_cmp++; if (inst_addr !== exp_addr[i]) begin n_fail++; $display("FAIL seq_addr%0d got %h exp %h", i, inst_addr, exp_addr[i]); end
      if (i == 2) begin
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'hbfc00000 || if_inst !== e_inst) begin
          n_fail++; $display("FAIL seq_out0 got v=%b pc=%h inst=%h exp v=1 pc=bfc00000 inst=%h", if_valid, if_pc, if_inst, e_inst);
        end
      end
      advance();
    end
    settle();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'hbfc00004) begin
      n_fail++; $display("FAIL seq_out1 got v=%b pc=%h exp v=1 pc=bfc00004", if_valid, if_pc);
    end
    advance();
  endtask

  task automatic test_max_out();
    logic [31:0] seen[$];
    bit          saw_req;
    do_reset();
    inst_addr_ok = 1'b1; resp_en = 1'b0;
    repeat (6) begin
      settle();
      if (inst_req && inst_addr_ok) seen.push_back(inst_addr);
      advance();
    end
    n_cmp++; if (seen.size() != 2) begin n_fail++; $display("FAIL maxout_count got %0d exp 2", seen.size()); end
    else begin
      n_cmp++; if (seen[0] !== 32'hbfc00000 || seen[1] !== 32'hbfc00004) begin
        n_fail++; $display("FAIL maxout_addrs got %h,%h exp bfc00000,bfc00004", seen[0], seen[1]);
      end
    end
    settle();
    n_cmp++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL maxout_blocked got %b exp 0", inst_req); end
    advance();
    resp_en = 1'b1;
    saw_req = 1'b0;
    repeat (4) begin settle(); if (inst_req) saw_req = 1'b1; advance(); end
    n_cmp++; if (saw_req !== 1'b1) begin n_fail++; $display("FAIL maxout_resume got %b exp 1", saw_req); end
  endtask

  task automatic test_branch_cancel();
    bit          got;
    logic [31:0] first_pc;
    do_reset();
    inst_addr_ok = 1'b1; resp_en = 1'b0;
    repeat (3) begin settle(); advance(); end
    branch = 1'b1; b_addr = 32'h80000100;
    settle();
    n_cmp++; if (inst_req !== 1'b0 || if_valid !== 1'b0) begin
      n_fail++; $display("FAIL branch_cycle got req=%b v=%b exp 0 0", inst_req, if_valid);
    end
    advance();
    branch = 1'b0; resp_en = 1'b1; resp_pct = 100;
    settle();
    n_cmp++; if (inst_req !== 1'b1 || inst_addr !== 32'h80000100) begin
      n_fail++; $display("FAIL branch_target got req=%b addr=%h exp 1 80000100", inst_req, inst_addr);
    end
    advance();
    got = 1'b0; first_pc = '0;
    repeat (8) begin
      settle();
      if (if_valid && !got) begin got = 1'b1; first_pc = if_pc; end
      advance();
    end
    n_cmp++; if (got !== 1'b1 || first_pc !== 32'h80000100) begin
      n_fail++; $display("FAIL branch_drop got v=%b pc=%h exp 1 80000100", got, first_pc);
    end
  endtask

  task automatic test_flush_priority();
    do_reset();
    inst_addr_ok = 1'b1; resp_en = 1'b1; resp_pct = 100;
    repeat (2) begin settle(); advance(); end
    stall = 1'b1;
    repeat (2) begin settle(); advance(); end
    settle();
    n_cmp++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre got v=%b exp 1", if_valid); end
    advance();
    flush = 1'b1; flush_pc = 32'hbfc00380; branch = 1'b1; b_addr = 32'h80000000;
    settle();
    n_cmp++; if (if_valid !== 1'b0 || inst_req !== 1'b0) begin
      n_fail++; $display("FAIL flush_cycle got v=%b req=%b exp 0 0", if_valid, inst_req);
    end
    advance();
    flush = 1'b0; branch = 1'b0;
    repeat (2) begin
      settle();
      n_cmp++; if (inst_addr !== 32'hbfc00380 || if_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_target got addr=%h v=%b exp bfc00380 0", inst_addr, if_valid);
      end
      advance();
    end
    stall = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    inst_addr_ok = 1'b1; resp_en = 1'b1; resp_pct = 100;
    repeat (2) begin settle(); advance(); end
    stall = 1'b1;
    repeat (4) begin
      settle();
      n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'hbfc00000 || inst_req !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold got v=%b pc=%h req=%b exp 1 bfc00000 0", if_valid, if_pc, inst_req);
      end
      advance();
    end
    stall = 1'b0;
    settle();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'hbfc00000) begin
      n_fail++; $display("FAIL stall_pop0 got v=%b pc=%h exp 1 bfc00000", if_valid, if_pc);
    end
    advance();
    settle();
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'hbfc00004) begin
      n_fail++; $display("FAIL stall_pop1 got v=%b pc=%h exp 1 bfc00004", if_valid, if_pc);
    end
    advance();
  endtask

  task automatic test_wrap();
    do_reset();
    stall = 1'b1; branch = 1'b1; b_addr = 32'hfffffffc; inst_addr_ok = 1'b1;
    settle();
    n_cmp++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL wrap_redirect got req=%b exp 0", inst_req); end
    advance();
    stall = 1'b0; branch = 1'b0;
    settle();
    n_cmp++; if (inst_req !== 1'b1 || inst_addr !== 32'hfffffffc) begin
      n_fail++; $display("FAIL wrap_pre got req=%b addr=%h exp 1 fffffffc", inst_req, inst_addr);
    end
    advance();
    settle();
    n_cmp++; if (inst_addr !== 32'h00000000) begin n_fail++; $display("FAIL wrap_post got %h exp 00000000", inst_addr); end
    advance();
  endtask

  task automatic test_random();
    do_reset();
    resp_en = 1'b1; resp_pct = 60;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst          = ($urandom_range(199, 0) == 0);
      stall        = ($urandom_range(99, 0) < 30);
      inst_addr_ok = ($urandom_range(99, 0) < 70);
      flush        = (m_cancel == 0) && ($urandom_range(99, 0) < 3);
      branch       = (m_cancel == 0) && ($urandom_range(99, 0) < 5);
      flush_pc     = $urandom;
      b_addr       = ($urandom_range(3, 0) == 0) ? 32'hfffffff8 : $urandom;
      settle();
      n_cmp++;
      if (inst_req !== e_req || inst_addr !== e_addr || if_valid !== e_valid ||
          (e_valid && (if_pc !== e_pc || if_inst !== e_inst))) begin
        n_fail++;
        $display("FAIL rand cyc %0d got req=%b addr=%h v=%b pc=%h inst=%h exp req=%b addr=%h v=%b pc=%h inst=%h",
                 cyc, inst_req, inst_addr, if_valid, if_pc, if_inst, e_req, e_addr, e_valid, e_pc, e_inst);
      end
      advance();
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0; branch = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_sequential();
    test_max_out();
    test_branch_cancel();
    test_flush_priority();
    test_stall();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter ADDR_W, 32, address/instruction width in bits.
REQ-002 Parameter RESET_PC, 32'hbfc00000, first fetch address after reset.
REQ-003 Parameter PC_STEP, 4, PC increment per accepted request.
REQ-004 Parameter MAX_OUT, 2 (range 1..4), maximum fetches in flight plus buffered.
REQ-005 Reset rst, synchronous, active-high; clock clk.
REQ-006 clk  in  1  clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 stall  in  1  downstream stall; blocks new requests and output consumption.
REQ-009 flush, flush_pc  in  1, ADDR_W  exception redirect and its target.
REQ-010 branch, b_addr  in  1, ADDR_W  branch redirect and its target.
REQ-011 inst_req, inst_addr  out  1, ADDR_W  memory request and fetch address.
REQ-012 inst_addr_ok  in  1  request accepted this cycle.
REQ-013 inst_data_ok, inst_rdata  in  1, ADDR_W  response valid and instruction word, in request order.
REQ-014 if_valid, if_pc, if_inst  out  1, ADDR_W, ADDR_W  fetched instruction to decode.

Function
REQ-015 ce register: 0 during rst, 1 from the first clk edge with rst low; no request while ce=0.
REQ-016 pc register: RESET_PC while ce=0; inst_addr = pc combinationally.
REQ-017 inst_req = ce & !stall & !flush & !branch & (outstanding + fifo_count) < MAX_OUT.
REQ-018 Accept (inst_req & inst_addr_ok): pc <= pc + PC_STEP (mod 2^ADDR_W); pc pushed into in-flight tag queue (depth MAX_OUT); outstanding +1.
REQ-019 Redirect priority: flush over branch; pc <= flush_pc or b_addr; inst_req forced 0 that cycle; if both asserted, only flush_pc is used.
REQ-020 On redirect: tag queue and result FIFO cleared; cancel_cnt <= outstanding after the same-cycle response is counted; outstanding <= 0.
REQ-021 Response (inst_data_ok) with cancel_cnt>0: dropped, cancel_cnt -1, no output.
REQ-022 Response with cancel_cnt=0 and no redirect: tag queue head popped, {tag, inst_rdata} pushed into result FIFO (depth MAX_OUT), outstanding -1.
REQ-023 Response with outstanding=0 and cancel_cnt=0: ignored, no state change.
REQ-024 if_valid = FIFO non-empty & !flush & !branch; if_pc/if_inst = FIFO head; latency data_ok -> if_valid exactly 1 cycle.
REQ-025 Pop on if_valid & !stall; while stall=1, if_valid/if_pc/if_inst hold unchanged.
REQ-026 Accept, response and pop in the same cycle all take effect; counters update by net sum.
REQ-027 Occupancy bound (REQ-017) guarantees no FIFO overflow; overflow is never reachable.
REQ-028 Redirect while stall=1 takes effect immediately; pc update does not depend on stall.

Reset
REQ-029 During rst: ce=0, pc=RESET_PC, outstanding=0, cancel_cnt=0, FIFOs empty, inst_req=0, if_valid=0.
REQ-030 rst asserted mid-operation discards all in-flight state; responses arriving during/after rst for pre-reset requests are ignored under REQ-023.

Verification
REQ-031 Reset release, addr_ok=1, data_ok one cycle after accept -> inst_addr bfc00000, bfc00004, bfc00008 in consecutive cycles; if_pc follows 2 cycles behind each accept.
REQ-032 MAX_OUT=2, data_ok held 0 -> exactly two accepts (bfc00000, bfc00004), then inst_req=0 until a response returns.
REQ-033 Two outstanding, branch=1 b_addr=80000100 -> next two responses dropped, no if_valid, next inst_addr=80000100.
REQ-034 flush=1 flush_pc=bfc00380 and branch=1 b_addr=80000000 same cycle -> pc=bfc00380, FIFO emptied, if_valid=0.
REQ-035 stall=1 with two responses buffered -> if_valid=1, if_pc held constant, inst_req=0; stall released -> two pops on consecutive cycles in order.
REQ-036 pc=fffffffc accepted -> next inst_addr=00000000 (wrap).
